// File: rtl/cmem_seq.sv
// cmem_seq: burst sequencer that owns the pins of the 64x16 coefficient SRAM.
// A valid/ready write stream becomes SRAM write cycles. A read command becomes
// a back-pressurable valid/ready stream. The one-cycle SRAM read latency is
// hidden behind a 2-entry output buffer.
module cmem_seq #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   burst_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {IDLE, LOAD, READ, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              push, pop, issue;
    logic [2:0]        used;
    logic [1:0]        slot;

    // SRAM pins are decoded from the state register, so the asynchronous reset
    // of state_q releases mem_cen the moment rst_n falls.
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf0_q;
    assign addr_inc  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

    // Next-state, SRAM pin and buffer bookkeeping for the current cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        in_ready   = 1'b0;
        mem_cen    = 1'b1;
        mem_wen    = 1'b1;
        mem_a      = '0;
        mem_d      = '0;
        push       = 1'b0;
        pop        = 1'b0;
        issue      = 1'b0;
        used       = 3'd0;
        case (state_q)
            IDLE: begin
                if (start_load || start_read) begin
                    addr_d = base_addr;
                    cnt_d  = burst_len;
                    if (burst_len == '0)
                        state_d = FIN;
                    else if (start_load)
                        state_d = LOAD;
                    else
                        state_d = READ;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_cen = 1'b0;
                    mem_wen = 1'b0;
                    mem_a   = addr_q;
                    mem_d   = in_data;
                    addr_d  = addr_inc;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == 1)
                        state_d = FIN;
                end
            end
            READ: begin
                pop  = out_valid && out_ready;
                push = inflight_q;
                // Slots committed after this cycle must not exceed the buffer.
                used  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
                issue = (cnt_q != '0) && (used < 3'd2);
                if (issue) begin
                    mem_cen = 1'b0;
                    mem_a   = addr_q;
                    addr_d  = addr_inc;
                    cnt_d   = cnt_q - 1'b1;
                end
                inflight_d = issue;
                occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
                if (cnt_d == '0 && !inflight_d && occ_d == 2'd0)
                    state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output buffer contents: head shifts on pop, returning word fills next free slot.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        slot   = occ_q - {1'b0, pop};
        if (pop)
            buf0_d = buf1_q;
        if (push) begin
            if (slot == 2'd0)
                buf0_d = mem_q;
            else
                buf1_d = mem_q;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

    // Buffer data needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

endmodule

// File: doc/cmem_seq.md
Name: cmem_seq

Overview:
- Sequencer that sits directly upstream of the 64x16 coefficient SRAM (cmem) and owns its CEN/WEN/A/D pins.
- Converts a valid/ready write stream into SRAM write cycles, and a read command into a back-pressurable valid/ready output stream.
- Hides the SRAM's one-cycle read latency behind a 2-entry output buffer, so downstream logic never touches raw SRAM timing.

Parameters:
- ADDR_W, 6, SRAM address width
- DATA_W, 16, SRAM data width
- DEPTH, 64, SRAM words; equals 2**ADDR_W

Ports:
- clk  in  1  single clock; also drives the SRAM CLK
- rst_n  in  1  asynchronous, active-low reset
- start_load  in  1  pulse: begin a write burst (sampled in IDLE only)
- start_read  in  1  pulse: begin a read burst (sampled in IDLE only)
- base_addr  in  ADDR_W  first SRAM address of the burst, sampled with the start pulse
- burst_len  in  ADDR_W+1  word count, 0..DEPTH, sampled with the start pulse
- in_valid  in  1  write-stream beat valid
- in_ready  out  1  write-stream beat accepted when in_valid & in_ready
- in_data  in  DATA_W  write-stream data
- out_valid  out  1  read-stream beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  read-stream data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at burst completion
- mem_cen  out  1  SRAM chip enable, active low
- mem_wen  out  1  SRAM write enable, active low
- mem_a  out  ADDR_W  SRAM address
- mem_d  out  DATA_W  SRAM write data
- mem_q  in  DATA_W  SRAM read data; valid in the cycle after a read-enabled clock edge

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - state IDLE
  - in_ready=0, out_valid=0, busy=0, done=0
  - mem_cen=1, mem_wen=1, mem_a=0, mem_d=0
  - output buffer empty, in-flight flag 0, counters 0
- FSM states: IDLE, LOAD, READ, FIN.
- IDLE:
  - start_load -> LOAD; start_load wins if start_load and start_read are high together.
  - Otherwise start_read -> READ.
  - base_addr and burst_len are latched on the transition.
  - Start pulses in any other state are ignored.
  - A start with burst_len=0 -> FIN directly, with no SRAM access.
- LOAD:
  - in_ready=1.
  - Each accepted beat drives, combinationally in the same cycle: mem_cen=0, mem_wen=0, mem_a=current address, mem_d=in_data. The SRAM writes on that rising edge.
  - Address increments modulo DEPTH (63 -> 0); the remaining count decrements.
  - On the last beat -> FIN.
  - No SRAM access in cycles without a handshake: mem_cen=1, mem_wen=1.
- READ:
  - in_ready=0 and mem_wen=1 at all times.
  - A read is issued (mem_cen=0, mem_a=current address) when words remain and (buffer occupancy + in-flight − pop this cycle) < 2.
  - The in-flight flag is set on issue. In the next cycle mem_q is pushed into the buffer and the flag clears.
  - out_valid = buffer non-empty; out_data = buffer head; pop on out_valid & out_ready.
  - Address wraps modulo DEPTH.
  - -> FIN when all words have been issued, nothing is in flight, and the buffer is empty (last pop done).
- FIN: done=1 for exactly one cycle, then -> IDLE.
- busy=1 in LOAD, READ and FIN.
- Latency: start_read accepted in cycle T → first mem_cen=0 in cycle T+1 → out_valid from cycle T+3.
  - With out_ready held high, sustained throughput is 1 word/cycle.
  - done rises the cycle after the last pop.
- Backpressure: with out_ready=0, at most 2 reads are outstanding (buffer full). No word is ever lost or duplicated.
- Buffer data is held stable while out_valid=1 and out_ready=0.
- Reset mid-burst: immediate return to IDLE and buffer cleared. mem_cen deasserts asynchronously, so no partial write is issued after rst_n falls.

Test Plan:
- Load base=0, len=64, data 0x0000..0x003F with in_valid held high → 64 consecutive write cycles, A=0..63; done pulses once, 1 cycle after the last beat; busy low afterwards.
- Read base=0, len=64, out_ready=1 → out_valid from T+3, out_data 0x0000..0x003F one per cycle with no gaps; done pulses after the word 0x003F pops.
- Read len=8 with out_ready toggling 1,0,0,1 → data sequence unchanged and in order; never more than 2 reads outstanding; out_data stable while stalled.
- Wrap-around: load base=60, len=8, data 0xA0..0xA7, then read base=60, len=8 → A sequence 60,61,62,63,0,1,2,3; data 0xA0..0xA7 returned.
- Edge starts:
  - len=0 → done in the next cycle, mem_cen never low.
  - start_load and start_read in the same cycle → only LOAD runs.
  - start_read during LOAD → ignored.
- Assert rst_n low mid-read (4 of 8 words popped) → out_valid=0 and mem_cen=1 immediately; a fresh read of the same range after reset returns the correct 8 words.
